// File: rtl/c_requant_packer.sv
`default_nettype none
// ============================================================================
// Module   : c_requant_packer
// Brief    : Requantizes the signed OW-bit C stream from the matmul core to
//            int8 (rounding shift, zero point, optional ReLU, saturation) and
//            packs four results per 32-bit AXIS word. Frame length checking
//            and a 2-entry output FIFO are included.
// Revision : 1.0 - initial release
// ============================================================================
module c_requant_packer #(
  parameter int OW        = 16,
  parameter int FRAME_LEN = 425,
  parameter int CNT_W     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [OW-1:0] s_axis_c_tdata,
  input  logic          s_axis_c_tvalid,
  output logic          s_axis_c_tready,
  input  logic          s_axis_c_tlast,
  input  logic [3:0]    cfg_shift,
  input  logic [7:0]    cfg_zp,
  input  logic          cfg_relu,
  output logic [31:0]   m_axis_tdata,
  output logic [3:0]    m_axis_tkeep,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tlast,
  output logic          frame_done,
  output logic          err_len
);

  localparam logic signed [OW+1:0] c_qmax      = (OW+2)'(127);
  localparam logic signed [OW+1:0] c_qmin      = (OW+2)'(-128);
  localparam logic [CNT_W:0]       c_frame_len = (CNT_W+1)'(FRAME_LEN);

  // ---------------------------------------------------------------- handshake
  logic w_accept;
  assign w_accept = s_axis_c_tvalid && s_axis_c_tready;

  // ------------------------------------------------------- config selection
  // The first beat of a frame uses the live config; the rest use the latch.
  logic             r_in_frame;
  logic [3:0]       r_shift;
  logic [7:0]       r_zp;
  logic             r_relu;
  logic [3:0]       w_shift;
  logic [7:0]       w_zp;
  logic             w_relu;

  assign w_shift = r_in_frame ? r_shift : cfg_shift;
  assign w_zp    = r_in_frame ? r_zp    : cfg_zp;
  assign w_relu  = r_in_frame ? r_relu  : cfg_relu;

  // ------------------------------------------------------ requant datapath
  logic signed [OW:0]   w_x;
  logic signed [OW:0]   w_half;
  logic signed [OW:0]   w_sum;
  logic signed [OW:0]   w_r;
  logic signed [OW+1:0] w_v;
  logic [7:0]           w_q;

  assign w_x    = {s_axis_c_tdata[OW-1], s_axis_c_tdata};
  // Half-LSB bias gives round-half-up; zero when no shift so x passes through.
  assign w_half = (w_shift == 4'd0) ? '0 : ((OW+1)'(1) << (w_shift - 4'd1));
  assign w_sum  = w_x + w_half;
  assign w_r    = w_sum >>> w_shift;
  assign w_v    = {w_r[OW], w_r} + {{(OW-6){w_zp[7]}}, w_zp};

  // Optional ReLU followed by int8 saturation.
  always_comb begin
    w_q = w_v[7:0];
    if (w_relu && w_v[OW+1]) begin
      w_q = 8'h00;
    end else if (w_v > c_qmax) begin
      w_q = 8'h7F;
    end else if (w_v < c_qmin) begin
      w_q = 8'h80;
    end
  end

  // ---------------------------------------------------------------- packing
  logic [1:0]  r_lane_cnt;
  logic [31:0] r_pack_buf;
  logic [31:0] w_word;
  logic [3:0]  w_keep;
  logic        w_push;

  assign w_word = r_pack_buf | ({24'd0, w_q} << {r_lane_cnt, 3'b000});
  assign w_push = w_accept && ((r_lane_cnt == 2'd3) || s_axis_c_tlast);

  // Keep mask covers lanes 0..lane_cnt of the word being completed.
  always_comb begin
    w_keep = 4'b0001;
    case (r_lane_cnt)
      2'd0:    w_keep = 4'b0001;
      2'd1:    w_keep = 4'b0011;
      2'd2:    w_keep = 4'b0111;
      default: w_keep = 4'b1111;
    endcase
  end

  // Lane accumulation; buffer clears once its word goes to the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane_cnt <= 2'd0;
      r_pack_buf <= 32'd0;
    end else if (w_accept) begin
      if (w_push) begin
        r_lane_cnt <= 2'd0;
        r_pack_buf <= 32'd0;
      end else begin
        r_lane_cnt <= r_lane_cnt + 2'd1;
        r_pack_buf <= w_word;
      end
    end
  end

  // ------------------------------------------------------------ output FIFO
  logic [31:0] r_fifo_data [2];
  logic [3:0]  r_fifo_keep [2];
  logic [1:0]  r_fifo_last;
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic [1:0]  w_count_next;
  logic        w_pop;

  assign m_axis_tvalid = (r_count != 2'd0);
  assign w_pop         = m_axis_tvalid && m_axis_tready;
  assign m_axis_tdata  = m_axis_tvalid ? r_fifo_data[r_rd_ptr] : 32'd0;
  assign m_axis_tkeep  = m_axis_tvalid ? r_fifo_keep[r_rd_ptr] : 4'd0;
  assign m_axis_tlast  = m_axis_tvalid ? r_fifo_last[r_rd_ptr] : 1'b0;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  // FIFO storage and pointers; input ready mirrors the post-update occupancy
  // so a full FIFO never sees another push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fifo_data[0]  <= 32'd0;
      r_fifo_data[1]  <= 32'd0;
      r_fifo_keep[0]  <= 4'd0;
      r_fifo_keep[1]  <= 4'd0;
      r_fifo_last     <= 2'd0;
      r_wr_ptr        <= 1'b0;
      r_rd_ptr        <= 1'b0;
      r_count         <= 2'd0;
      s_axis_c_tready <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= w_word;
        r_fifo_keep[r_wr_ptr] <= w_keep;
        r_fifo_last[r_wr_ptr] <= s_axis_c_tlast;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count         <= w_count_next;
      s_axis_c_tready <= (w_count_next < 2'd2);
    end
  end

  // -------------------------------------------------------- frame tracking
  logic [CNT_W-1:0] r_elem_cnt;
  logic [CNT_W:0]   w_elem_plus1;

  assign w_elem_plus1 = {1'b0, r_elem_cnt} + (CNT_W+1)'(1);

  // Element counting, config latch, sticky length error and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_elem_cnt <= '0;
      r_in_frame <= 1'b0;
      r_shift    <= 4'd0;
      r_zp       <= 8'd0;
      r_relu     <= 1'b0;
      err_len    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_accept && s_axis_c_tlast;
      if (w_accept) begin
        if (!r_in_frame) begin
          r_shift <= cfg_shift;
          r_zp    <= cfg_zp;
          r_relu  <= cfg_relu;
        end
        if (s_axis_c_tlast) begin
          if (w_elem_plus1 != c_frame_len) begin
            err_len <= 1'b1;
          end
          r_elem_cnt <= '0;
          r_in_frame <= 1'b0;
        end else begin
          r_in_frame <= 1'b1;
          if (!(&r_elem_cnt)) begin
            r_elem_cnt <= r_elem_cnt + 1'b1;
          end
          // Reaching the expected length without tlast means the frame overruns.
          if (w_elem_plus1 == c_frame_len) begin
            err_len <= 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_c_requant_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_c_requant_packer
// Brief    : Self-checking bench for c_requant_packer (FRAME_LEN = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_c_requant_packer;

  localparam int OW        = 16;
  localparam int FRAME_LEN = 4;
  localparam int CNT_W     = 16;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s_axis_c_tdata = '0;
  logic        s_axis_c_tvalid = 1'b0;
  logic        s_axis_c_tready;
  logic        s_axis_c_tlast = 1'b0;
  logic [3:0]  cfg_shift = '0;
  logic [7:0]  cfg_zp = '0;
  logic        cfg_relu = 1'b0;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        frame_done;
  logic        err_len;

  c_requant_packer #(.OW(OW), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .s_axis_c_tdata(s_axis_c_tdata), .s_axis_c_tvalid(s_axis_c_tvalid),
    .s_axis_c_tready(s_axis_c_tready), .s_axis_c_tlast(s_axis_c_tlast),
    .cfg_shift(cfg_shift), .cfg_zp(cfg_zp), .cfg_relu(cfg_relu),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .frame_done(frame_done), .err_len(err_len)
  );

  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    stab_err = 0;
  int    fd_cnt = 0;
  int    fd_exp = 0;
  logic  err_exp = 1'b0;
  logic  rdy_rand = 1'b0;
  logic  rdy_val  = 1'b0;
  int    frame_x[$];
  word_t got[$];
  word_t exp_q[$];
  word_t p_w;
  logic  p_stall = 1'b0;

  // Output ready driver: fixed level or random per cycle.
  always @(posedge clk) begin
    #1;
    m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
  end

  // Output monitor: records popped words, checks stall stability, counts done pulses.
  always @(negedge clk) begin
    if (rst) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall && (!m_axis_tvalid || ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== p_w)))
        stab_err++;
      if (m_axis_tvalid && m_axis_tready)
        got.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast});
      p_stall = m_axis_tvalid && !m_axis_tready;
      p_w     = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
      if (frame_done) fd_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference requantizer using exact floor division.
  function automatic logic [7:0] ref_q(input int x, input int sh, input int zp, input logic relu);
    int r, v, d, t;
    if (sh == 0) begin
      r = x;
    end else begin
      d = 1 << sh;
      t = x + d / 2;
      if (t >= 0) r = t / d;
      else        r = -((-t + d - 1) / d);
    end
    v = r + zp;
    if (relu && v < 0) v = 0;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return v[7:0];
  endfunction

  // Frame model: chunk the frame's results into groups of four.
  task automatic model_frame(input int sh, input int zp, input logic relu);
    int    n;
    word_t w;
    n = frame_x.size();
    for (int g = 0; g < n; g += 4) begin
      w = '0;
      for (int k = 0; k < 4; k++) begin
        if (g + k < n) begin
          w.d[8*k +: 8] = ref_q(frame_x[g+k], sh, zp, relu);
          w.k[k] = 1'b1;
        end
      end
      w.l = (g + 4 >= n);
      exp_q.push_back(w);
    end
    if (n != FRAME_LEN) err_exp = 1'b1;
    fd_exp++;
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send_beat(input int x, input logic last);
    int   guard;
    logic acc;
    guard = 0;
    acc   = 1'b0;
    s_axis_c_tdata  = 16'(x);
    s_axis_c_tlast  = last;
    s_axis_c_tvalid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      if (s_axis_c_tready) acc = 1'b1;
      @(posedge clk); #1;
      guard++;
      if (!acc && guard > 400) begin
        check("accept_timeout", {63'd0, acc}, 64'd1);
        break;
      end
    end
    s_axis_c_tvalid = 1'b0;
    s_axis_c_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int sh, input int zp, input logic relu,
                            input logic gaps, input logic scramble);
    int n;
    n = frame_x.size();
    cfg_shift = 4'(sh);
    cfg_zp    = 8'(zp);
    cfg_relu  = relu;
    model_frame(sh, zp, relu);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      send_beat(frame_x[i], i == n - 1);
      if (i == 0 && scramble) begin
        cfg_shift = 4'($urandom);
        cfg_zp    = 8'($urandom);
        cfg_relu  = 1'($urandom);
      end
    end
  endtask

  task automatic wait_words(input int n, input string tag);
    int guard;
    guard = 0;
    while (got.size() < n && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (4) @(posedge clk);
    #1;
    check(tag, 64'(got.size()), 64'(n));
  endtask

  task automatic clear_q();
    got.delete();
    exp_q.delete();
  endtask

  task automatic compare_model(input string tag);
    wait_words(exp_q.size(), {tag, "_count"});
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got.size()) check($sformatf("%s_w%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
    clear_q();
  endtask

  task automatic directed(input string tag, input int sh, input int zp, input logic relu,
                          input logic [36:0] expw);
    send_frame(sh, zp, relu, 1'b0, 1'b0);
    wait_words(1, {tag, "_count"});
    if (got.size() > 0) check(tag, 64'(got[0]), 64'(expw));
    clear_q();
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    s_axis_c_tvalid = 1'b0;
    @(posedge clk); #1;
    clear_q();
    fd_cnt = 0; fd_exp = 0; err_exp = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tready"}, 64'(s_axis_c_tready), 64'd0);
    check({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    check({tag, "_tdata"},  64'(m_axis_tdata), 64'd0);
    check({tag, "_tkeep"},  64'(m_axis_tkeep), 64'd0);
    check({tag, "_tlast"},  64'(m_axis_tlast), 64'd0);
    check({tag, "_done"},   64'(frame_done), 64'd0);
    check({tag, "_err"},    64'(err_len), 64'd0);
  endtask

  initial begin
    int n, sh, zp;
    logic relu;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("tready_after_rst", 64'(s_axis_c_tready), 64'd1);
    rdy_val = 1'b1;

    // Directed requant / packing cases
    frame_x = '{1, 2, 3, 4};
    directed("basic", 0, 0, 1'b0, {32'h04030201, 4'hF, 1'b1});
    frame_x = '{300, -200, 127, -128};
    directed("sat", 0, 0, 1'b0, {32'h807F807F, 4'hF, 1'b1});
    directed("zp5", 0, 5, 1'b0, {32'h857F807F, 4'hF, 1'b1});
    frame_x = '{5, 6, -6, -7};
    directed("round", 2, 0, 1'b0, {32'hFEFF0201, 4'hF, 1'b1});
    directed("relu", 2, 0, 1'b1, {32'h00000201, 4'hF, 1'b1});
    check("basic_done_cnt", 64'(fd_cnt), 64'(fd_exp));
    check("basic_err", 64'(err_len), 64'(err_exp));

    // Partial trailing word (6 beats against FRAME_LEN 4)
    frame_x = '{1, 2, 3, 4, 5, 6};
    send_frame(0, 0, 1'b0, 1'b0, 1'b0);
    wait_words(2, "partial_count");
    if (got.size() > 1) begin
      check("partial_w0", 64'(got[0]), 64'({32'h04030201, 4'hF, 1'b0}));
      check("partial_w1", 64'(got[1]), 64'({32'h00000605, 4'h3, 1'b1}));
    end
    clear_q();
    check("partial_err", 64'(err_len), 64'(err_exp));

    // Backpressure: FIFO fills after two words and stalls input
    do_reset();
    rdy_val = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    frame_x = '{1, 2, 3, 4};
    send_frame(0, 0, 1'b0, 1'b0, 1'b0);
    frame_x = '{5, 6, 7, 8};
    send_frame(0, 0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("bp_tready_low", 64'(s_axis_c_tready), 64'd0);
    check("bp_no_out", 64'(got.size()), 64'd0);
    check("bp_head_valid", 64'(m_axis_tvalid), 64'd1);
    rdy_val = 1'b1;
    frame_x = '{9, 10, 11, 12};
    send_frame(0, 0, 1'b0, 1'b0, 1'b0);
    compare_model("bp");
    check("bp_err", 64'(err_len), 64'(err_exp));

    // Random frames, random gaps, random output ready, mid-frame cfg churn
    rdy_rand = 1'b1;
    for (int f = 0; f < 30; f++) begin
      n = ($urandom_range(0, 1) == 1) ? 4 : int'($urandom_range(1, 9));
      frame_x.delete();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) frame_x.push_back(int'($signed(16'($urandom))));
        else                           frame_x.push_back(int'($urandom_range(0, 1200)) - 600);
      end
      sh   = int'($urandom_range(0, 15));
      zp   = int'($urandom_range(0, 255)) - 128;
      relu = 1'($urandom);
      send_frame(sh, zp, relu, 1'b1, 1'b1);
    end
    compare_model("rand");
    check("rand_done_cnt", 64'(fd_cnt), 64'(fd_exp));
    check("rand_err", 64'(err_len), 64'(err_exp));
    rdy_rand = 1'b0;
    rdy_val  = 1'b1;

    // Length error is sticky; mid-frame reset clears everything
    do_reset();
    frame_x = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    send_frame(0, 0, 1'b0, 1'b0, 1'b0);
    compare_model("len10");
    check("err_set", 64'(err_len), 64'(err_exp));
    frame_x = '{-1, -2, -3, -4};
    send_frame(1, 3, 1'b0, 1'b0, 1'b0);
    compare_model("after_err");
    check("err_sticky", 64'(err_len), 64'(err_exp));

    cfg_shift = 4'd0; cfg_zp = 8'd0; cfg_relu = 1'b0;
    send_beat(7, 1'b0);
    send_beat(8, 1'b0);
    send_beat(9, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    clear_q();
    fd_cnt = 0; fd_exp = 0; err_exp = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    frame_x = '{1, 2, 3, 4};
    directed("fresh", 0, 0, 1'b0, {32'h04030201, 4'hF, 1'b1});
    check("fresh_err", 64'(err_len), 64'(err_exp));
    check("fresh_done_cnt", 64'(fd_cnt), 64'(fd_exp));

    check("stall_stable", 64'(stab_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
